// File: rtl/decode_stage.sv
// decode_stage: buffered instruction decode between fetch and execute.
// Instructions are decoded as they enter and the decoded result is held in a
// DEPTH-entry FIFO; a flush (taken branch) discards everything buffered.
// Optional macro DECODE_ILLEGAL_TRAP_EN: when defined, illegal instructions are
// replaced by a NOP in the buffer and flagged on the illegal output; when
// undefined, illegal is tied low and instructions pass through unmodified.
module decode_stage #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [31:0]     instr_out,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  // Opcodes the stage recognises as legal; everything else is illegal.
  function automatic logic is_legal(input logic [31:0] ins);
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
      7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
      7'b1101111, 7'b0110011, 7'b0001111: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

  // Format-correct immediate selected by opcode; formats without one give 0.
  function automatic logic [XLEN-1:0] imm_of(input logic [31:0] ins);
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
        imm_of = {{20{ins[31]}}, ins[31:20]};
      7'b0100011:
        imm_of = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      7'b1100011:
        imm_of = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm_of = {ins[31:12], 12'b0};
      7'b1101111:
        imm_of = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:
        imm_of = '0;
    endcase
  endfunction

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] imm_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic            push;
  logic            pop;
  logic [31:0]     instr_store;
  logic [XLEN-1:0] imm_store;

  assign in_ready  = (count_reg < DEPTH_C);
  assign out_valid = (count_reg != '0);
  // Flush wins: nothing offered or consumed in a flush cycle takes effect.
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_mem [DEPTH];
  logic illegal_in;

  assign illegal_in  = ~is_legal(instr_in);
  assign instr_store = illegal_in ? 32'h0000_0013 : instr_in;
  assign illegal     = illegal_mem[rd_ptr_reg];

  // Legality bit stored alongside the (possibly NOP-substituted) entry.
  always_ff @(posedge clk) begin
    if (push) illegal_mem[wr_ptr_reg] <= illegal_in;
  end
`else
  assign instr_store = instr_in;
  assign illegal     = 1'b0;
`endif

  assign imm_store = imm_of(instr_store);

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= pc_in;
      instr_mem[wr_ptr_reg] <= instr_store;
      imm_mem[wr_ptr_reg]   <= imm_store;
    end
  end

  // Pointer and occupancy bookkeeping with flush taking priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + ONE_C;
        2'b01:   count_reg <= count_reg - ONE_C;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign pc_out    = pc_mem[rd_ptr_reg];
  assign instr_out = instr_mem[rd_ptr_reg];
  assign imm       = imm_mem[rd_ptr_reg];
  assign opcode    = instr_out[6:0];
  assign rd        = instr_out[11:7];
  assign funct3    = instr_out[14:12];
  assign rs1       = instr_out[19:15];
  assign rs2       = instr_out[24:20];
  assign funct7    = instr_out[31:25];

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a
// queue-based reference model. Honours DECODE_ILLEGAL_TRAP_EN like the design.
module tb_decode_stage;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0] pc_in, instr_in, pc_out, instr_out, imm;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t q[$];

  decode_stage #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .pc_in(pc_in), .instr_in(instr_in),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
    .instr_out(instr_out), .opcode(opcode), .rd(rd), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .funct7(funct7), .imm(imm), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic bit legal_op(input logic [31:0] ins);
    logic [6:0] o;
    o = ins[6:0];
    return o inside {7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                     7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F};
  endfunction

  // Immediate from the format rules, built as signed values then widened.
  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    logic signed [11:0] v12;
    logic signed [12:0] v13;
    logic signed [20:0] v21;
    logic [6:0] o;
    o = i[6:0];
    if (o inside {7'h13, 7'h03, 7'h67, 7'h73}) begin
      v12 = i[31:20];
      return 32'(v12);
    end
    if (o == 7'h23) begin
      v12 = {i[31:25], i[11:7]};
      return 32'(v12);
    end
    if (o == 7'h63) begin
      v13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
      return 32'(v13);
    end
    if (o inside {7'h37, 7'h17}) return i & 32'hFFFF_F000;
    if (o == 7'h6F) begin
      v21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
      return 32'(v21);
    end
    return 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("comparison %s differs", tag);
    end
  endtask

  // Compare all visible outputs with the model's head entry.
  task automatic check_outputs();
    logic [31:0] ei;
    bit          bad;
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      ei  = q[0].instr;
      bad = !legal_op(ei);
`ifdef DECODE_ILLEGAL_TRAP_EN
      if (bad) ei = 32'h0000_0013;
      chk("illegal", 32'(illegal), 32'(bad));
`else
      chk("illegal", 32'(illegal), 32'd0);
`endif
      chk("pc_out", pc_out, q[0].pc);
      chk("instr_out", instr_out, ei);
      chk("opcode", 32'(opcode), 32'(ei[6:0]));
      chk("rd", 32'(rd), 32'(ei[11:7]));
      chk("funct3", 32'(funct3), 32'(ei[14:12]));
      chk("rs1", 32'(rs1), 32'(ei[19:15]));
      chk("rs2", 32'(rs2), 32'(ei[24:20]));
      chk("funct7", 32'(funct7), 32'(ei[31:25]));
      chk("imm", imm, ref_imm(ei));
    end
  endtask

  // One clock: check at the negedge, drive, advance the model at the posedge.
  task automatic step(input bit iv, input logic [31:0] pc, input logic [31:0] ins,
                      input bit ordy, input bit fl);
    bit pushed, popped;
    check_outputs();
    in_valid = iv; pc_in = pc; instr_in = ins; out_ready = ordy; flush = fl;
    pushed = iv && (q.size() < DEPTH);
    popped = ordy && (q.size() != 0);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (popped) void'(q.pop_front());
      if (pushed) q.push_back('{pc, ins});
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12];
    logic [31:0] r;
    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
            7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h00};
    r = $urandom;
    if ($urandom_range(0, 5) == 0) return r;
    return {r[31:7], ops[$urandom_range(0, 11)]};
  endfunction

  initial begin
    reset = 1'b1; flush = 0; in_valid = 0; out_ready = 0; pc_in = 0; instr_in = 0;
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // addi x1,x0,5
    step(1, 32'h0, 32'h0050_0093, 0, 0);
    check_outputs();
    chk("addi_rd", 32'(rd), 32'd1);
    chk("addi_imm", imm, 32'h5);
    step(0, 0, 0, 1, 0);

    // beq x0,x0,-4 then lui x5,0x12345
    step(1, 32'h10, 32'hFE00_0EE3, 0, 0);
    check_outputs();
    chk("beq_imm", imm, 32'hFFFF_FFFC);
    chk("beq_op", 32'(opcode), 32'h63);
    step(1, 32'h14, 32'h1234_52B7, 1, 0);
    check_outputs();
    chk("lui_rd", 32'(rd), 32'd5);
    chk("lui_imm", imm, 32'h1234_5000);
    step(0, 0, 0, 1, 0);

    // Backpressure: third offer held until space frees up.
    step(1, 32'h0, 32'h0000_0013, 0, 0);
    step(1, 32'h4, 32'h0010_0113, 0, 0);
    chk("full_ready", 32'(in_ready), 32'd0);
    step(1, 32'h8, 32'h0020_0193, 0, 0);
    step(1, 32'h8, 32'h0020_0193, 1, 0);
    chk("pop1_pc", pc_out, 32'h4);
    step(1, 32'h8, 32'h0020_0193, 1, 0);
    chk("pop2_pc", pc_out, 32'h8);
    step(0, 0, 0, 1, 0);

    // Flush with push and pop offered in the same cycle.
    step(1, 32'h20, 32'h0050_0093, 0, 0);
    step(1, 32'h24, 32'h0050_0093, 0, 0);
    step(1, 32'h28, 32'h1234_52B7, 1, 1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    step(0, 0, 0, 1, 0);

    // Asynchronous reset in the middle of a cycle with two entries held.
    step(1, 32'h30, 32'h0050_0093, 0, 0);
    step(1, 32'h34, 32'h0050_0093, 0, 0);
    in_valid = 0;
    #2 reset = 1'b1;
    #1 chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    step(1, 32'h40, 32'h0050_0093, 0, 0);
    chk("post_rst_imm", imm, 32'h5);
    step(0, 0, 0, 1, 0);

    // All-zero word is illegal.
    step(1, 32'h50, 32'h0000_0000, 0, 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("zero_illegal", 32'(illegal), 32'd1);
    chk("zero_instr", instr_out, 32'h0000_0013);
`else
    chk("zero_illegal", 32'(illegal), 32'd0);
    chk("zero_instr", instr_out, 32'h0000_0000);
`endif
    chk("zero_imm", imm, 32'h0);
    step(0, 0, 0, 1, 0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      step(bit'($urandom_range(0, 3) != 0), $urandom, rand_instr(),
           bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 15) == 0));
    end
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Buffered decode stage directly downstream of instruction fetch. Accepts {PC, instr} pairs over a valid/ready handshake and decodes them at entry: register fields, opcode/funct, format-correct sign-extended immediate, legality. Holds decoded results in a DEPTH-entry FIFO for the execute stage. A flush input, driven by the taken-branch select, discards all buffered instructions.

Parameters:
DEPTH, 2, FIFO entries; power of two, >=2
XLEN, 32, data/address width; only 32 supported

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of all buffered entries (taken branch)
in_valid  in  1  fetch presents pc_in/instr_in
in_ready  out  1  stage can accept this cycle
pc_in  in  XLEN  PC of fetched instruction
instr_in  in  32  fetched instruction word
out_valid  out  1  head entry valid
out_ready  in  1  execute consumes head this cycle
pc_out  out  XLEN  head PC
instr_out  out  32  head instruction word
opcode  out  7  instr[6:0]
rd  out  5  instr[11:7]
funct3  out  3  instr[14:12]
rs1  out  5  instr[19:15]
rs2  out  5  instr[24:20]
funct7  out  7  instr[31:25]
imm  out  XLEN  sign-extended immediate
illegal  out  1  head instruction illegal (feature-dependent)

Behaviour:
- Reset (async): wr_ptr=rd_ptr=0, count=0; out_valid=0, in_ready=1. Data outputs are don't-care while out_valid=0; bench must not check them.
- in_ready = (count < DEPTH). It does not depend on out_ready, so a push into a full FIFO is never accepted, even when a pop occurs in the same cycle.
- Push = in_valid & in_ready: decode instr_in combinationally and write {pc, instr, fields, imm, illegal} at wr_ptr. wr_ptr wraps modulo DEPTH.
- Pop = out_valid & out_ready: rd_ptr advances modulo DEPTH.
- out_valid = (count != 0). All outputs come from the entry at rd_ptr.
- Latency: push in cycle N appears at the outputs in cycle N+1 if the FIFO was empty.
- Simultaneous push and pop: count unchanged; FIFO order is preserved.
- flush has priority over push and pop in the same cycle: pointers=0, count=0, the input offered that cycle is dropped. Next cycle: out_valid=0, in_ready=1.
- Fields are raw bit slices regardless of format.
- Immediate by opcode:
  - I-type: 0010011, 0000011, 1100111, 1110011 -> sext(instr[31:20])
  - S-type: 0100011 -> sext({instr[31:25], instr[11:7]})
  - B-type: 1100011 -> sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - U-type: 0110111, 0010111 -> {instr[31:12], 12'b0}
  - J-type: 1101111 -> sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
  - R-type 0110011, FENCE 0001111, all others -> 0
- Legal: instr[1:0]==2'b11 and opcode is in the list above. Anything else is illegal.
- Reset asserted mid-operation empties the FIFO immediately; no partial entries survive.

Optional Feature:
DECODE_ILLEGAL_TRAP_EN
- Defined: the illegal port reflects the stored legality bit. An illegal instruction is stored with instr_out=32'h00000013 (NOP), fields and imm decoded from that NOP, and pc_out unchanged.
- Undefined: illegal is tied to 0 and illegal instructions pass through unmodified, with imm=0.

Test Plan:
- Empty FIFO, push pc=0x0, instr=0x00500093 (addi x1,x0,5) -> next cycle: out_valid=1, rd=1, rs1=0, funct3=0, imm=0x00000005, pc_out=0x0.
- Push 0xFE000EE3 (beq x0,x0,-4) at pc=0x10 -> imm=0xFFFFFFFC, opcode=0x63. Push 0x123452B7 (lui x5,0x12345) -> rd=5, imm=0x12345000.
- out_ready=0, offer pcs 0x0, 0x4, 0x8 on consecutive cycles -> in_ready=0 after 2 pushes, 0x8 held upstream. Then out_ready=1 -> pops 0x0 then 0x4, 0x8 accepted, order preserved, count never exceeds 2.
- Full FIFO, assert flush with in_valid=1 and out_ready=1 in the same cycle -> next cycle out_valid=0, in_ready=1. The flushed-cycle input never appears at the outputs.
- Two entries buffered, assert reset asynchronously mid-cycle -> out_valid=0 immediately, in_ready=1. After release, a push of 0x00500093 decodes correctly.
- Push 0x00000000 -> with DECODE_ILLEGAL_TRAP_EN: illegal=1, instr_out=0x00000013, imm=0. Without it: illegal=0, instr_out=0x00000000, imm=0.
